// File: rtl/mul_div_unit.sv
// Multi-cycle signed multiply (Booth radix-2) / divide (restoring) engine.
// One WIDTH-iteration run, a sign-fixup cycle, then a single-cycle done pulse.
module mul_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] MUL_RUN = 3'd1;
   localparam logic [2:0] DIV_RUN = 3'd2;
   localparam logic [2:0] FIXUP   = 3'd3;
   localparam logic [2:0] DONE    = 3'd4;

   logic [2:0]       state;
   logic [CW-1:0]    cnt;
   // acc is the Booth accumulator for MUL and the partial remainder for DIV;
   // mq is the multiplier/low product for MUL and the quotient for DIV.
   logic [WIDTH:0]   acc;
   logic [WIDTH-1:0] mq;
   logic [WIDTH-1:0] mcand;
   logic             q_1;
   logic             op_r, sa, sb, bz;
   logic [WIDTH-1:0] a_r;

   logic [WIDTH-1:0] a_mag, b_mag, quo_s, rem_s;
   logic [WIDTH:0]   a_ext, booth_sum, div_shift, div_trial;

   always_comb begin
      a_mag     = a[WIDTH-1] ? -a : a;
      b_mag     = b[WIDTH-1] ? -b : b;
      a_ext     = {mcand[WIDTH-1], mcand};
      booth_sum = acc;
      case ({mq[0], q_1})
         2'b01:   booth_sum = acc + a_ext;
         2'b10:   booth_sum = acc - a_ext;
         default: booth_sum = acc;
      endcase
      div_shift = {acc[WIDTH-1:0], mq[WIDTH-1]};
      div_trial = div_shift - {1'b0, mcand};
      // Truncating division: quotient sign from sign(a)^sign(b), remainder follows a.
      quo_s     = (sa ^ sb) ? -mq : mq;
      rem_s     = sa ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
   end

   assign busy = (state == MUL_RUN) || (state == DIV_RUN) || (state == FIXUP);
   assign done = (state == DONE);

   always_ff @(posedge clk) begin
      if (!clr) begin
         state       <= IDLE;
         cnt         <= '0;
         acc         <= '0;
         mq          <= '0;
         mcand       <= '0;
         q_1         <= 1'b0;
         op_r        <= 1'b0;
         sa          <= 1'b0;
         sb          <= 1'b0;
         bz          <= 1'b0;
         a_r         <= '0;
         hi          <= '0;
         lo          <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               op_r        <= op;
               a_r         <= a;
               sa          <= a[WIDTH-1];
               sb          <= b[WIDTH-1];
               bz          <= (b == '0);
               cnt         <= '0;
               acc         <= '0;
               q_1         <= 1'b0;
               div_by_zero <= 1'b0;
               if (op) begin
                  mq    <= a_mag;
                  mcand <= b_mag;
                  state <= DIV_RUN;
               end else begin
                  mq    <= b;
                  mcand <= a;
                  state <= MUL_RUN;
               end
            end
            MUL_RUN: begin
               {acc, mq, q_1} <= {booth_sum[WIDTH], booth_sum, mq};
               cnt            <= cnt + 1'b1;
               if (cnt == LAST) state <= FIXUP;
            end
            DIV_RUN: begin
               if (!div_trial[WIDTH]) begin
                  acc <= div_trial;
                  mq  <= {mq[WIDTH-2:0], 1'b1};
               end else begin
                  acc <= div_shift;
                  mq  <= {mq[WIDTH-2:0], 1'b0};
               end
               cnt <= cnt + 1'b1;
               if (cnt == LAST) state <= FIXUP;
            end
            FIXUP: begin
               if (op_r) begin
                  if (bz) begin
                     hi          <= a_r;
                     lo          <= '1;
                     div_by_zero <= 1'b1;
                  end else begin
                     hi <= rem_s;
                     lo <= quo_s;
                  end
               end else begin
                  hi <= acc[WIDTH-1:0];
                  lo <= mq;
               end
               state <= DONE;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: driver pushes model results, monitor
// pops and compares on every done pulse.
module tb_mul_div_unit;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         clr;
   logic         start;
   logic         op;
   logic [W-1:0] a, b;
   logic         busy, done, div_by_zero;
   logic [W-1:0] hi, lo;

   mul_div_unit #(.WIDTH(W)) dut (
      .clk(clk), .clr(clr), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dbz;
      int           start_cyc;
   } exp_t;

   exp_t         sb_q[$];
   int           cyc = 0;
   int           total = 0;
   int           bad = 0;
   int           busy_cnt = 0;
   logic [W-1:0] held_hi = '0, held_lo = '0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Reference: plain signed 64-bit arithmetic; SV '/' and '%' truncate toward zero.
   function automatic exp_t model(input bit o, input logic [W-1:0] x, input logic [W-1:0] y);
      exp_t        e;
      longint      sx, sy, q, r;
      logic [63:0] p;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      e.dbz = 1'b0;
      e.start_cyc = 0;
      if (!o) begin
         p    = sx * sy;
         e.hi = p[63:32];
         e.lo = p[31:0];
      end else if (y == '0) begin
         e.hi  = x;
         e.lo  = '1;
         e.dbz = 1'b1;
      end else begin
         q    = sx / sy;
         r    = sx % sy;
         p    = q;
         e.lo = p[31:0];
         p    = r;
         e.hi = p[31:0];
      end
      return e;
   endfunction

   // Monitor
   always @(negedge clk) begin
      exp_t e;
      if (!clr) begin
         busy_cnt = 0;
         held_hi  = '0;
         held_lo  = '0;
      end else begin
         if (busy) begin
            busy_cnt++;
            chk("hold_hi_during_run", hi, held_hi);
            chk("hold_lo_during_run", lo, held_lo);
         end
         if (done) begin
            chk("busy_and_done", busy, 0);
            if (sb_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
            end else begin
               e = sb_q.pop_front();
               chk("hi", hi, e.hi);
               chk("lo", lo, e.lo);
               chk("div_by_zero", div_by_zero, e.dbz);
               chk("latency", cyc, e.start_cyc + W + 2);
               chk("busy_cycles", busy_cnt, W + 1);
            end
            held_hi  = hi;
            held_lo  = lo;
            busy_cnt = 0;
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      @(posedge clk); #2;
      while ((busy || done) && n < 200) begin
         @(posedge clk); #2;
         n++;
      end
      if (n >= 200) begin
         total++;
         bad++;
         $display("FAIL idle_timeout: got busy=%0b done=%0b expected idle", busy, done);
      end
   endtask

   task automatic issue(input bit o, input logic [W-1:0] x, input logic [W-1:0] y);
      exp_t e;
      wait_idle();
      e = model(o, x, y);
      e.start_cyc = cyc;
      sb_q.push_back(e);
      op = o; a = x; b = y; start = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
      a = $urandom; b = $urandom; op = 1'($urandom);
   endtask

   task automatic pulse_in_done();
      int n = 0;
      @(posedge clk); #2;
      while (!done && n < 200) begin
         @(posedge clk); #2;
         n++;
      end
      if (n >= 200) begin
         total++;
         bad++;
         $display("FAIL done_timeout: got done=0 expected done pulse");
      end
      op = 1'b0; a = 32'd9; b = 32'd9; start = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 7))
         0:       return '0;
         1:       return 32'h8000_0000;
         2:       return '1;
         3:       return 32'd1;
         4:       return W'($urandom_range(1, 20));
         5:       return -W'($urandom_range(1, 20));
         default: return W'($urandom);
      endcase
   endfunction

   initial begin
      int n;
      clr = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_dbz", div_by_zero, 0);
      chk("reset_hi", hi, 0);
      chk("reset_lo", lo, 0);
      #1 clr = 1'b1;

      // Directed cases
      issue(1'b0, 32'd7, 32'hFFFF_FFFD);
      repeat (8) @(posedge clk);
      #2 op = 1'b1; a = 32'd5; b = 32'd5; start = 1'b1;
      @(posedge clk); #2 start = 1'b0;
      pulse_in_done();
      issue(1'b0, 32'h8000_0000, 32'h8000_0000);
      issue(1'b1, 32'hFFFF_FFEF, 32'd5);
      issue(1'b1, 32'd100, 32'd17);
      issue(1'b1, 32'd100, 32'd0);
      issue(1'b0, 32'd2, 32'd3);
      issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
      issue(1'b1, 32'h8000_0000, 32'd1);
      issue(1'b1, 32'd17, 32'hFFFF_FFFB);

      // Reset in the middle of a run: pending result is discarded
      issue(1'b0, 32'h1234_5678, 32'h9ABC_DEF0);
      repeat (18) @(posedge clk);
      #2 clr = 1'b0;
      void'(sb_q.pop_back());
      @(posedge clk); #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      chk("midrst_hi", hi, 0);
      chk("midrst_lo", lo, 0);
      chk("midrst_dbz", div_by_zero, 0);
      #1 clr = 1'b1;

      // Random mix
      for (int i = 0; i < 40; i++) issue(1'($urandom), pick(), pick());

      n = 0;
      while (sb_q.size() > 0 && n < 500) begin
         @(posedge clk);
         n++;
      end
      if (sb_q.size() > 0) begin
         total++;
         bad++;
         $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
      end
      repeat (40) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
